serial_add_ctrl: RTL

//  Bit-serial addition controller. Sequences one external 1-bit full adder

---
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial addition controller. Drives one external 1-bit full-adder cell
//   over WIDTH cycles to form a_in + b_in + cin_in, LSB first. It owns the
//   operand shift registers, the carry flop, the sum register and the bit
//   counter.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   start             request, sampled only while idle
//   a_in, b_in        WIDTH-bit operands, captured when start is accepted
//   cin_in            carry-in, captured when start is accepted
//   fa_a, fa_b        to the full adder: current operand LSBs (0 when not running)
//   fa_cin            to the full adder: running carry (0 when not running)
//   fa_sout, fa_cout  from the full adder: sum bit and carry-out
//   busy              high while bits are being added
//   done              one-cycle pulse when sum_out/cout_out are valid
//   sum_out, cout_out result, held until the next accepted start
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sout,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry_q;
  logic [CW-1:0]    count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (count == LAST) begin
          last_bit  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // New sum bit enters at the MSB; after WIDTH shifts the LSB is at bit 0
  if (WIDTH == 1) begin : g_sum_w1
    assign sum_nxt = fa_sout;
  end else begin : g_sum_wn
    assign sum_nxt = {fa_sout, sum_sh[WIDTH-1:1]};
  end

  // Datapath and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry_q  <= 1'b0;
      count    <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (accept) begin
        a_sh    <= a_in;
        b_sh    <= b_in;
        carry_q <= cin_in;
        count   <= '0;
        sum_sh  <= '0;
      end else if (state == S_RUN) begin
        sum_sh  <= sum_nxt;
        carry_q <= fa_cout;
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        // Hold on the final bit so the counter never wraps mid-operation
        if (!last_bit) begin
          count <= count + CW'(1);
        end
        if (last_bit) begin
          sum_out  <= sum_nxt;
          cout_out <= fa_cout;
        end
      end
    end
  end

  // Adder inputs are gated so a shared cell sees zeros when not running
  assign fa_a   = busy & a_sh[0];
  assign fa_b   = busy & b_sh[0];
  assign fa_cin = busy & carry_q;

endmodule
